// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Parity modes, FSM states and the default bit divisor.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 50 MHz system clock at 9600 baud
    localparam int DEF_CLK_DIV = 50_000_000 / 9600;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Word output handshake of the UART receiver.
// The receiver is master; the consumer drives ready.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output data_out, valid, frame_err,
        output parity_err, overrun,
        input  ready
    );

    modport slave (
        input  data_out, valid, frame_err,
        input  parity_err, overrun,
        output ready
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// RX synchronizer, in-bit counter and 3-sample majority vote.
// bit_tick marks the commit count; bit_val is the voted bit.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic clear,
    output logic fall,
    output logic bit_tick,
    output logic bit_val
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int H  = CLK_DIV / 2;

    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] C_HM1  = CW'(H - 1);
    localparam logic [CW-1:0] C_H    = CW'(H);
    localparam logic [CW-1:0] C_HP1  = CW'(H + 1);

    logic [1:0]    sync;
    logic          rx_q;
    logic [CW-1:0] cnt;
    logic          smp0;
    logic          smp1;

    // clear lands on the detect edge, which is itself count 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            rx_q <= 1'b1;
            cnt  <= '0;
            smp0 <= 1'b1;
            smp1 <= 1'b1;
        end else begin
            sync <= {sync[0], rx};
            rx_q <= sync[1];
            if (clear)
                cnt <= C_ONE;
            else if (cnt == C_LAST)
                cnt <= '0;
            else
                cnt <= cnt + C_ONE;
            if (cnt == C_HM1)
                smp0 <= sync[1];
            if (cnt == C_H)
                smp1 <= sync[1];
        end
    end

    assign fall     = rx_q & ~sync[1];
    assign bit_tick = (cnt == C_HP1);
    assign bit_val  = maj3(smp0, smp1, sync[1]);

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: frame FSM, shift register
// and a valid/ready output register with error flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic busy,
    uart_rx_core_if.master rxo
);

    localparam logic [3:0] B_ONE   = 4'd1;
    localparam logic [3:0] B_DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] B_SLAST = 4'(STOP_BITS - 1);

    state_t               state;
    logic [3:0]           bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 perr;
    logic                 ferr;
    logic                 done_q;
    logic                 fall;
    logic                 tick;
    logic                 bval;
    logic                 clear;

    logic [DATA_BITS-1:0] dout_q;
    logic                 valid_q;
    logic                 fe_q;
    logic                 pe_q;
    logic                 ov_q;

    assign clear = (state == ST_IDLE) && fall;

    uart_rx_sampler #(
        .CLK_DIV (CLK_DIV)
    ) u_sampler (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .clear    (clear),
        .fall     (fall),
        .bit_tick (tick),
        .bit_val  (bval)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bcnt    <= '0;
            shreg   <= '0;
            par_acc <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            done_q  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state   <= ST_START;
                        bcnt    <= '0;
                        par_acc <= 1'b0;
                        perr    <= 1'b0;
                        ferr    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (bval) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg   <= {bval, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ bval;
                        if (bcnt == B_DLAST) begin
                            bcnt  <= '0;
                            state <= (PARITY != PAR_NONE) ?
                                     ST_PARITY : ST_STOP;
                        end else begin
                            bcnt <= bcnt + B_ONE;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        perr  <= (PARITY == PAR_ODD) ?
                                 ~(par_acc ^ bval) :
                                 (par_acc ^ bval);
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // leave at mid-stop so the next start edge is caught
                    if (tick) begin
                        ferr <= ferr | ~bval;
                        if (bcnt == B_SLAST) begin
                            state  <= ST_IDLE;
                            busy   <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            bcnt <= bcnt + B_ONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // a finished frame is dropped, not merged, while a word waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else if (valid_q && rxo.ready) begin
            ov_q <= 1'b0;
            if (done_q) begin
                dout_q <= shreg;
                fe_q   <= ferr;
                pe_q   <= perr;
            end else begin
                valid_q <= 1'b0;
            end
        end else if (done_q) begin
            if (!valid_q) begin
                dout_q  <= shreg;
                fe_q    <= ferr;
                pe_q    <= perr;
                valid_q <= 1'b1;
            end else begin
                ov_q <= 1'b1;
            end
        end
    end

    assign rxo.data_out   = dout_q;
    assign rxo.valid      = valid_q;
    assign rxo.frame_err  = fe_q;
    assign rxo.parity_err = pe_q;
    assign rxo.overrun    = ov_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: 8N1, 8E1 and 8N2
// instances at CLK_DIV=16 with a queue of expected words.
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int DIV = 16;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       ov;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_a, rx_b, rx_c;
    logic busy_a, busy_b, busy_c;

    int   total = 0;
    int   bad   = 0;
    obs_t sbq[$];

    always #5 clk = ~clk;

    uart_rx_core_if #(.DATA_BITS(8)) ia ();
    uart_rx_core_if #(.DATA_BITS(8)) ib ();
    uart_rx_core_if #(.DATA_BITS(8)) ic ();

    uart_rx_core #(
        .CLK_DIV(DIV), .DATA_BITS(8),
        .PARITY(PAR_NONE), .STOP_BITS(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a),
        .busy(busy_a), .rxo(ia.master)
    );

    uart_rx_core #(
        .CLK_DIV(DIV), .DATA_BITS(8),
        .PARITY(PAR_EVEN), .STOP_BITS(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b),
        .busy(busy_b), .rxo(ib.master)
    );

    uart_rx_core #(
        .CLK_DIV(DIV), .DATA_BITS(8),
        .PARITY(PAR_NONE), .STOP_BITS(2)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .rx(rx_c),
        .busy(busy_c), .rxo(ic.master)
    );

    function automatic obs_t obs(input int sel);
        obs_t o;
        case (sel)
            0: o = {ia.valid, ia.data_out, ia.frame_err,
                    ia.parity_err, ia.overrun};
            1: o = {ib.valid, ib.data_out, ib.frame_err,
                    ib.parity_err, ib.overrun};
            default: o = {ic.valid, ic.data_out, ic.frame_err,
                          ic.parity_err, ic.overrun};
        endcase
        return o;
    endfunction

    task automatic drive(input int sel, input logic v);
        case (sel)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // spk selects one bit that gets a 1-clk inverted spike at count H
    task automatic send(input int sel, input logic [15:0] bits,
                        input int n, input int spk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(sel, bits[i]);
            if (i == spk) begin
                repeat (8) @(negedge clk);
                drive(sel, ~bits[i]);
                @(negedge clk);
                drive(sel, bits[i]);
                repeat (6) @(negedge clk);
            end else begin
                repeat (15) @(negedge clk);
            end
        end
    endtask

    task automatic wait_valid(input int sel, input int lim,
                              output bit ok);
        obs_t o;
        int   n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < lim) begin
            @(negedge clk);
            n++;
            o = obs(sel);
            if (o.v)
                ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        ia.ready = 1'b1; ib.ready = 1'b1; ic.ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            o = obs(s);
            total++;
            if (o !== '0) begin
                bad++;
                $display("FAIL reset_out%0d got=%h want=0", s, o);
            end
        end
        total++;
        if ({busy_a, busy_b, busy_c} !== 3'b000) begin
            bad++;
            $display("FAIL reset_busy got=%b want=000",
                     {busy_a, busy_b, busy_c});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        o = obs(0);
        total++;
        if ({o.v, busy_a} !== 2'b00) begin
            bad++;
            $display("FAIL idle_quiet got=%b want=00", {o.v, busy_a});
        end
    endtask

    task automatic test_basic();
        obs_t e, o;
        ia.ready = 1'b1;
        sbq.push_back({1'b1, 8'hA5, 3'b000});
        fork
            send(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, -1);
            begin
                @(negedge clk);
                // t0 is the 3rd posedge; valid due at t0+154
                repeat (3 + 9 * DIV + 9) @(posedge clk);
                @(negedge clk);
                total++;
                if (ia.valid !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_early got=%b want=0", ia.valid);
                end
                @(negedge clk);
                o = obs(0);
                e = sbq.pop_front();
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL basic_word got=%h want=%h", o, e);
                end
                @(negedge clk);
                total++;
                if (ia.valid !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_pulse got=%b want=0", ia.valid);
                end
            end
        join
    endtask

    task automatic test_parity();
        obs_t e, o;
        bit   ok;
        sbq.push_back({1'b1, 8'h3C, 3'b000});
        sbq.push_back({1'b1, 8'h3C, 3'b010});
        fork
            begin
                send(1, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, -1);
                send(1, {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, -1);
            end
            for (int k = 0; k < 2; k++) begin
                wait_valid(1, 400, ok);
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL parity_timeout%0d got=none want=valid", k);
                end else begin
                    e = sbq.pop_front();
                    o = obs(1);
                    if (o !== e) begin
                        bad++;
                        $display("FAIL parity_word%0d got=%h want=%h",
                                 k, o, e);
                    end
                end
            end
        join
    endtask

    task automatic test_stop2();
        obs_t e, o;
        bit   ok;
        sbq.push_back({1'b1, 8'h55, 3'b100});
        fork
            send(2, {5'b0, 1'b0, 1'b1, 8'h55, 1'b0}, 11, -1);
            begin
                wait_valid(2, 400, ok);
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL stop2_timeout got=none want=valid");
                end else begin
                    e = sbq.pop_front();
                    o = obs(2);
                    if (o !== e) begin
                        bad++;
                        $display("FAIL stop2_word got=%h want=%h", o, e);
                    end
                end
            end
        join
        @(negedge clk);
        drive(2, 1'b1);
    endtask

    task automatic test_glitch();
        int seen;
        @(negedge clk);
        drive(0, 1'b0);
        repeat (5) @(negedge clk);
        total++;
        if (busy_a !== 1'b1) begin
            bad++;
            $display("FAIL glitch_detect got=%b want=1", busy_a);
        end
        drive(0, 1'b1);
        repeat (8) @(negedge clk);
        total++;
        if (busy_a !== 1'b0) begin
            bad++;
            $display("FAIL glitch_busy got=%b want=0", busy_a);
        end
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (ia.valid === 1'b1)
                seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL glitch_valid got=%0d want=0", seen);
        end
    endtask

    task automatic test_spike();
        obs_t e, o;
        bit   ok;
        sbq.push_back({1'b1, 8'hA5, 3'b000});
        fork
            send(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 3);
            begin
                wait_valid(0, 400, ok);
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL spike_timeout got=none want=valid");
                end else begin
                    e = sbq.pop_front();
                    o = obs(0);
                    if (o !== e) begin
                        bad++;
                        $display("FAIL spike_word got=%h want=%h", o, e);
                    end
                end
            end
        join
    endtask

    task automatic test_overrun();
        obs_t e, o;
        bit   ok;
        ia.ready = 1'b0;
        sbq.push_back({1'b1, 8'h11, 3'b000});
        sbq.push_back({1'b1, 8'h11, 3'b001});
        fork
            begin
                send(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, -1);
                send(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, -1);
            end
            begin
                wait_valid(0, 400, ok);
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL ovr_timeout got=none want=valid");
                end else begin
                    e = sbq.pop_front();
                    o = obs(0);
                    if (o !== e) begin
                        bad++;
                        $display("FAIL ovr_first got=%h want=%h", o, e);
                    end
                end
            end
        join
        repeat (4) @(negedge clk);
        e = sbq.pop_front();
        o = obs(0);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL ovr_hold got=%h want=%h", o, e);
        end
        ia.ready = 1'b1;
        @(negedge clk);
        total++;
        if ({ia.valid, ia.overrun} !== 2'b00) begin
            bad++;
            $display("FAIL ovr_clear got=%b want=00",
                     {ia.valid, ia.overrun});
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        bit   ok;
        ia.ready = 1'b0;
        sbq.push_back({1'b1, 8'h7E, 3'b000});
        fork
            send(0, {6'b0, 1'b1, 8'h7E, 1'b0}, 10, -1);
            begin
                wait_valid(0, 400, ok);
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL rst_pre_timeout got=none want=valid");
                end else begin
                    e = sbq.pop_front();
                    o = obs(0);
                    if (o !== e) begin
                        bad++;
                        $display("FAIL rst_pre_word got=%h want=%h", o, e);
                    end
                end
            end
        join
        fork
            send(0, {6'b0, 1'b1, 8'h7E, 1'b0}, 10, -1);
            begin
                repeat (60) @(negedge clk);
                total++;
                if (busy_a !== 1'b1) begin
                    bad++;
                    $display("FAIL rst_busy_pre got=%b want=1", busy_a);
                end
                rst_n = 1'b0;
                #1;
                o = obs(0);
                total++;
                if ({o, busy_a} !== 13'b0) begin
                    bad++;
                    $display("FAIL rst_async got=%h want=0", {o, busy_a});
                end
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        ia.ready = 1'b1;
        sbq.push_back({1'b1, 8'h7E, 3'b000});
        fork
            send(0, {6'b0, 1'b1, 8'h7E, 1'b0}, 10, -1);
            begin
                wait_valid(0, 400, ok);
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL rst_post_timeout got=none want=valid");
                end else begin
                    e = sbq.pop_front();
                    o = obs(0);
                    if (o !== e) begin
                        bad++;
                        $display("FAIL rst_post_word got=%h want=%h", o, e);
                    end
                end
            end
        join
    endtask

    task automatic test_break();
        obs_t e, got;
        int   cnt;
        cnt = 0;
        got = '0;
        ia.ready = 1'b1;
        sbq.push_back({1'b1, 8'h00, 3'b100});
        fork
            begin
                @(negedge clk);
                drive(0, 1'b0);
                repeat (DIV * 20) @(negedge clk);
                drive(0, 1'b1);
                repeat (40) @(negedge clk);
            end
            for (int i = 0; i < DIV * 20 + 40; i++) begin
                @(negedge clk);
                if (ia.valid === 1'b1) begin
                    cnt++;
                    got = obs(0);
                end
            end
        join
        e = sbq.pop_front();
        total++;
        if (cnt !== 1) begin
            bad++;
            $display("FAIL break_count got=%0d want=1", cnt);
        end
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL break_word got=%h want=%h", got, e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_glitch();
        test_spike();
        test_overrun();
        test_reset_mid();
        test_break();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
